// File: rtl/vec_mul_pkg.sv
// Shared types, defaults and helpers for the lane-multiplexed vector multiplier.
package vec_mul_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LANES      = 8;
    localparam int DEF_UNITS      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of multiplier beats needed to cover every lane.
    function automatic int beats(input int lanes, input int units);
        return lanes / units;
    endfunction

endpackage

// File: rtl/lane_mul.sv
// One shared lane multiplier: low half of the product plus an overflow flag
// telling whether the full product fits in DATA_WIDTH bits.
module lane_mul #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] prod_lo,
    output logic                  ovf
);

    logic [2*DATA_WIDTH-1:0] full_u;
    logic [2*DATA_WIDTH-1:0] full_s;
    logic [2*DATA_WIDTH-1:0] full;
    logic [DATA_WIDTH-1:0]   hi;

    // Zero-extended operands give the unsigned product; sign-extended operands
    // give the two's-complement product modulo 2^(2*DATA_WIDTH).
    assign full_u = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    assign full_s = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};

    // Select the product flavour and derive overflow from the discarded high half.
    always_comb begin
        full    = is_signed ? full_s : full_u;
        prod_lo = full[DATA_WIDTH-1:0];
        hi      = full[2*DATA_WIDTH-1:DATA_WIDTH];
        if (is_signed) begin
            ovf = (hi != {DATA_WIDTH{full[DATA_WIDTH-1]}});
        end else begin
            ovf = (hi != '0);
        end
    end

endmodule

// File: rtl/vec_mul_scheduler.sv
// Vector multiply over a small pool of shared lane multipliers. UNITS lanes
// are computed per cycle, so a full vector takes BEATS = LANES/UNITS cycles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE (and never during rst); out_valid is high
// only in DONE. Neither ready nor valid depends combinationally on the
// opposite side of its own handshake. There is no accept during the
// hand-off cycle, so back-to-back vectors start BEATS+2 edges apart.
module vec_mul_scheduler
    import vec_mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int UNITS      = DEF_UNITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_signed,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    operand1,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    operand2,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    out,
    output logic [LANES-1:0]                    ovf,
    output logic                                busy
);

    localparam int BEATS  = beats(LANES, UNITS);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    if (LANES % UNITS != 0) begin : g_bad_cfg
        $error("vec_mul_scheduler: LANES must be a multiple of UNITS");
    end

    state_t state;
    state_t state_next;

    logic [BEAT_W-1:0]                 beat;
    logic [31:0]                       beat_ext;
    logic                              last_beat;
    logic [LANES-1:0][DATA_WIDTH-1:0]  op1_q;
    logic [LANES-1:0][DATA_WIDTH-1:0]  op2_q;
    logic                              signed_q;

    logic [LANE_W-1:0]     lane_idx [UNITS];
    logic [DATA_WIDTH-1:0] a_sel    [UNITS];
    logic [DATA_WIDTH-1:0] b_sel    [UNITS];
    logic [DATA_WIDTH-1:0] prod_lo  [UNITS];
    logic                  unit_ovf [UNITS];

    assign beat_ext  = 32'(beat);
    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Multiplier u serves lane beat*UNITS+u of the latched operands.
    for (genvar u = 0; u < UNITS; u++) begin : g_unit
        assign lane_idx[u] = LANE_W'(beat_ext * 32'(UNITS) + 32'(u));
        assign a_sel[u]    = op1_q[lane_idx[u]];
        assign b_sel[u]    = op2_q[lane_idx[u]];

        lane_mul #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane_mul (
            .a        (a_sel[u]),
            .b        (b_sel[u]),
            .is_signed(signed_q),
            .prod_lo  (prod_lo[u]),
            .ovf      (unit_ovf[u])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, run BEATS cycles, hold until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = BUSY;
            BUSY: if (last_beat) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then fill UNITS result lanes per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            out      <= '0;
            ovf      <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op1_q    <= operand1;
                        op2_q    <= operand2;
                        signed_q <= in_signed;
                        out      <= '0;
                        ovf      <= '0;
                        beat     <= '0;
                    end
                end
                BUSY: begin
                    for (int u = 0; u < UNITS; u++) begin
                        out[lane_idx[u]] <= prod_lo[u];
                        ovf[lane_idx[u]] <= unit_ovf[u];
                    end
                    beat <= last_beat ? '0 : beat + BEAT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mul_scheduler.sv
// Directed bench for vec_mul_scheduler at DATA_WIDTH=8, LANES=8, UNITS=2.
module tb_vec_mul_scheduler;

    localparam int W     = 8;
    localparam int L     = 8;
    localparam int BEATS = 4;

    // Directed vectors, lane 0 in the least significant byte.
    localparam logic [63:0] A1 = 64'h0807060504030201;
    localparam logic [63:0] B1 = 64'h0303030303030303;
    localparam logic [63:0] E1 = 64'h1815120F0C090603;
    localparam logic [7:0]  V1 = 8'h00;

    localparam logic [63:0] A2 = 64'h000000000000FF10;
    localparam logic [63:0] B2 = 64'h0000000000000110;
    localparam logic [63:0] E2 = 64'h000000000000FF00;
    localparam logic [7:0]  V2 = 8'h01;

    localparam logic [63:0] A3 = 64'h000000007F8080FD;
    localparam logic [63:0] B3 = 64'h0000000002FF0105;
    localparam logic [63:0] E3 = 64'h00000000FE8080F1;
    localparam logic [7:0]  V3 = 8'h0C;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_signed;
    logic [L-1:0][W-1:0]     operand1;
    logic [L-1:0][W-1:0]     operand2;
    logic                    out_valid;
    logic                    out_ready;
    logic [L-1:0][W-1:0]     res;
    logic [L-1:0]            res_ovf;
    logic                    busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [L*W-1:0] exp_q[$];
    logic [L-1:0]   exp_ovf_q[$];

    vec_mul_scheduler #(
        .DATA_WIDTH(W),
        .LANES     (L),
        .UNITS     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_signed(in_signed),
        .operand1 (operand1),
        .operand2 (operand2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (res),
        .ovf      (res_ovf),
        .busy     (busy)
    );

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector and hold it until accepted; returns after the accepting edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s, output int ok);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        operand1  = a;
        operand2  = b;
        in_signed = s;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            ok = 0;
        end else begin
            tick();
            ok = 1;
        end
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, including the accepting edge already taken.
    task automatic wait_out(output int edges);
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_valid_timeout: out_valid=%0b after %0d edges, required 1", out_valid, edges);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (res !== '0)         begin n_err++; $display("FAIL reset_out: got %h want 0", res); end
        n_cmp++; if (res_ovf !== '0)     begin n_err++; $display("FAIL reset_ovf: got %h want 0", res_ovf); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_unsigned_basic();
        int ok;
        int edges;
        out_ready = 1'b1;
        send(A1, B1, 1'b0, ok);
        if (ok != 0) begin
            n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL basic_busy: got %0b want 1", busy); end
            n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL basic_in_ready_busy: got %0b want 0", in_ready); end
            wait_out(edges);
            n_cmp++; if (edges != BEATS + 1) begin n_err++; $display("FAIL basic_latency: got %0d edges want %0d", edges, BEATS + 1); end
            n_cmp++; if (res !== E1)         begin n_err++; $display("FAIL basic_out: got %h want %h", res, E1); end
            n_cmp++; if (res_ovf !== V1)     begin n_err++; $display("FAIL basic_ovf: got %h want %h", res_ovf, V1); end
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_one_cycle: got %0b want 0", out_valid); end
            n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL basic_back_idle: got %0b want 1", in_ready); end
        end
    endtask

    task automatic test_unsigned_overflow();
        int ok;
        int edges;
        out_ready = 1'b1;
        send(A2, B2, 1'b0, ok);
        if (ok != 0) begin
            wait_out(edges);
            n_cmp++; if (res !== E2)     begin n_err++; $display("FAIL uovf_out: got %h want %h", res, E2); end
            n_cmp++; if (res_ovf !== V2) begin n_err++; $display("FAIL uovf_ovf: got %h want %h", res_ovf, V2); end
            tick();
        end
    endtask

    task automatic test_signed();
        int ok;
        int edges;
        out_ready = 1'b1;
        send(A3, B3, 1'b1, ok);
        if (ok != 0) begin
            wait_out(edges);
            n_cmp++; if (res !== E3)     begin n_err++; $display("FAIL signed_out: got %h want %h", res, E3); end
            n_cmp++; if (res_ovf !== V3) begin n_err++; $display("FAIL signed_ovf: got %h want %h", res_ovf, V3); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int ok;
        int edges;
        out_ready = 1'b0;
        send(A3, B3, 1'b1, ok);
        if (ok != 0) begin
            wait_out(edges);
            for (int i = 0; i < 10; i++) begin
                in_valid  = 1'b1;
                operand1  = A1;
                operand2  = B1;
                in_signed = 1'b0;
                tick();
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
                n_cmp++; if (res !== E3)         begin n_err++; $display("FAIL bp_out[%0d]: got %h want %h", i, res, E3); end
                n_cmp++; if (res_ovf !== V3)     begin n_err++; $display("FAIL bp_ovf[%0d]: got %h want %h", i, res_ovf, V3); end
                n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
            n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
            tick();
            n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL bp_no_stray_accept: got busy %0b want 0", busy); end
        end
    endtask

    task automatic test_reset_midop();
        int ok;
        int edges;
        out_ready = 1'b1;
        send(A1, B1, 1'b0, ok);
        if (ok != 0) begin
            tick();
            tick();
            rst = 1'b1;
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
            n_cmp++; if (res !== '0)         begin n_err++; $display("FAIL midrst_out: got %h want 0", res); end
            n_cmp++; if (res_ovf !== '0)     begin n_err++; $display("FAIL midrst_ovf: got %h want 0", res_ovf); end
            n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL midrst_in_ready: got %0b want 0", in_ready); end
            n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL midrst_busy: got %0b want 0", busy); end
            tick();
            n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL midrst_in_ready_held: got %0b want 0", in_ready); end
            rst = 1'b0;
            tick();
            n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL midrst_release: got %0b want 1", in_ready); end
            send(A2, B2, 1'b0, ok);
            if (ok != 0) begin
                wait_out(edges);
                n_cmp++; if (res !== E2)     begin n_err++; $display("FAIL midrst_next_out: got %h want %h", res, E2); end
                n_cmp++; if (res_ovf !== V2) begin n_err++; $display("FAIL midrst_next_ovf: got %h want %h", res_ovf, V2); end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int acc;
        int got;
        int acc_edge[2];
        logic acc_next;
        logic [L*W-1:0] e_out;
        logic [L-1:0]   e_ovf;
        cyc = 0;
        acc = 0;
        got = 0;
        acc_edge[0] = 0;
        acc_edge[1] = 0;
        out_ready = 1'b1;
        exp_q.push_back(E1);
        exp_ovf_q.push_back(V1);
        exp_q.push_back(E3);
        exp_ovf_q.push_back(V3);
        in_valid  = 1'b1;
        operand1  = A1;
        operand2  = B1;
        in_signed = 1'b0;
        while ((acc < 2 || got < 2) && cyc < 60) begin
            acc_next = in_valid && in_ready;
            tick();
            cyc++;
            if (acc_next) begin
                acc_edge[acc] = cyc;
                acc++;
                if (acc == 1) begin
                    operand1  = A3;
                    operand2  = B3;
                    in_signed = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b2b_extra_result: got %h with nothing expected", res);
                end else begin
                    e_out = exp_q.pop_front();
                    e_ovf = exp_ovf_q.pop_front();
                    n_cmp++; if (res !== e_out)     begin n_err++; $display("FAIL b2b_out[%0d]: got %h want %h", got, res, e_out); end
                    n_cmp++; if (res_ovf !== e_ovf) begin n_err++; $display("FAIL b2b_ovf[%0d]: got %h want %h", got, res_ovf, e_ovf); end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        if (acc < 2 || got < 2) begin
            n_cmp++;
            n_err++;
            $display("FAIL b2b_timeout: accepts=%0d results=%0d want 2 and 2", acc, got);
        end else begin
            n_cmp++;
            if (acc_edge[1] - acc_edge[0] != BEATS + 2) begin
                n_err++;
                $display("FAIL b2b_interval: got %0d edges want %0d", acc_edge[1] - acc_edge[0], BEATS + 2);
            end
        end
        tick();
    endtask

    // Test sequence and final report.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        operand1  = '0;
        operand2  = '0;
        out_ready = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_unsigned_overflow();
        test_signed();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
